// File: rtl/demux_stream_1ton_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_stream_pkg
//  Description : Shared types and helpers for the 1-to-N stream demultiplexer.
//  Revision    : 1.0 - initial release
// ============================================================================
package demux_stream_pkg;

    // Per-slot action taken at the next clock edge
    typedef enum logic [1:0] {
        SLOT_HOLD  = 2'd0,
        SLOT_LOAD  = 2'd1,
        SLOT_DRAIN = 2'd2
    } slot_op_t;

    // Saturation value of an unsigned counter of the given width
    function automatic logic [63:0] cnt_max(input int unsigned width);
        if (width >= 64) begin
            return '1;
        end
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_stream_1ton_if.sv
`default_nettype none
// ============================================================================
//  Module      : demux_stream_1ton_if
//  Description : Producer-side and consumer-side handshake bundle of the
//                1-to-N stream demultiplexer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface demux_stream_1ton_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CH = 4
);
    localparam int unsigned c_sel_w = $clog2(NUM_CH);

    logic                       in_valid;
    logic                       in_ready;
    logic [DATA_W-1:0]          in_data;
    logic [c_sel_w-1:0]         in_sel;
    logic                       in_bcast;
    logic [NUM_CH-1:0]          out_valid;
    logic [NUM_CH-1:0]          out_ready;
    logic [NUM_CH*DATA_W-1:0]   out_data;

    // Environment view: drives the producer side, consumes the channels
    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Demultiplexer view
    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface
`default_nettype wire

// File: rtl/demux_stream_1ton_slot.sv
`default_nettype none
// ============================================================================
//  Module      : demux_stream_slot
//  Description : One-entry output slot (valid bit + data register) of a
//                single demultiplexer channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_stream_slot
    import demux_stream_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              load,
    input  wire logic [DATA_W-1:0] load_data,
    output logic                   out_valid,
    input  wire logic              out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic                   can_load
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
    } slot_rec_t;

    slot_rec_t r_slot;
    slot_op_t  w_op;

    // A load wins over a drain so the slot refills without a bubble
    always_comb begin
        w_op = SLOT_HOLD;
        if (load) begin
            w_op = SLOT_LOAD;
        end else if (r_slot.valid && out_ready) begin
            w_op = SLOT_DRAIN;
        end
    end

    // Slot register; data is kept on drain so an idle channel shows its last word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot <= '0;
        end else begin
            case (w_op)
                SLOT_LOAD:  r_slot       <= {1'b1, load_data};
                SLOT_DRAIN: r_slot.valid <= 1'b0;
                default:    r_slot       <= r_slot;
            endcase
        end
    end

    assign out_valid = r_slot.valid;
    assign out_data  = r_slot.data;
    assign can_load  = ~r_slot.valid | out_ready;

endmodule
`default_nettype wire

// File: rtl/demux_stream_1ton.sv
`default_nettype none
// ============================================================================
//  Module      : demux_stream_1ton
//  Description : Registered 1-to-NUM_CH stream demultiplexer with per-channel
//                one-entry slots, atomic broadcast and a saturating counter
//                of words dropped for an out-of-range select.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_stream_1ton
    import demux_stream_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    demux_stream_1ton_if.slave bus,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int unsigned      c_sel_w   = $clog2(NUM_CH);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(cnt_max(CNT_W));

    logic [NUM_CH-1:0]        w_sel_hit;
    logic [NUM_CH-1:0]        w_can_load;
    logic [NUM_CH-1:0]        w_load;
    logic [NUM_CH-1:0]        w_out_valid;
    logic [NUM_CH*DATA_W-1:0] w_out_data;
    logic                     w_sel_legal;
    logic                     w_in_ready;
    logic                     w_accept;
    logic                     w_drop;
    logic [CNT_W-1:0]         r_drop_cnt;

    // Per-channel select decode, load strobe and slot
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign w_sel_hit[k] = (bus.in_sel == c_sel_w'(k));
        assign w_load[k]    = w_accept & (bus.in_bcast | w_sel_hit[k]);

        demux_stream_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (w_load[k]),
            .load_data (bus.in_data),
            .out_valid (w_out_valid[k]),
            .out_ready (bus.out_ready[k]),
            .out_data  (w_out_data[k*DATA_W +: DATA_W]),
            .can_load  (w_can_load[k])
        );
    end

    // Input readiness: broadcast needs every slot free, unicast only its own,
    // an out-of-range select is always swallowed
    always_comb begin
        w_sel_legal = |w_sel_hit;
        w_in_ready  = 1'b1;
        if (rst) begin
            w_in_ready = 1'b0;
        end else if (bus.in_bcast) begin
            w_in_ready = &w_can_load;
        end else if (w_sel_legal) begin
            w_in_ready = |(w_sel_hit & w_can_load);
        end
    end

    assign w_accept = bus.in_valid & w_in_ready;
    assign w_drop   = w_accept & ~bus.in_bcast & ~w_sel_legal;

    // Saturating count of words consumed without a destination
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != c_cnt_max)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_data;
    assign drop_cnt      = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_demux_stream_1ton.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_stream_1ton
//  Description : Self-checking bench for demux_stream_1ton (4-channel main
//                instance, two 3-channel instances for out-of-range selects).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_stream_1ton;

    logic clk = 1'b0;
    logic rst;
    logic armed = 1'b0;

    always #5 clk = ~clk;

    demux_stream_1ton_if #(.DATA_W(8), .NUM_CH(4)) if4  ();
    demux_stream_1ton_if #(.DATA_W(8), .NUM_CH(3)) if3a ();
    demux_stream_1ton_if #(.DATA_W(8), .NUM_CH(3)) if3b ();

    logic [15:0] drop4;
    logic [15:0] drop3a;
    logic [1:0]  drop3b;

    demux_stream_1ton #(.DATA_W(8), .NUM_CH(4), .CNT_W(16)) dut4 (
        .clk(clk), .rst(rst), .bus(if4.slave), .drop_cnt(drop4)
    );
    demux_stream_1ton #(.DATA_W(8), .NUM_CH(3), .CNT_W(16)) dut3a (
        .clk(clk), .rst(rst), .bus(if3a.slave), .drop_cnt(drop3a)
    );
    demux_stream_1ton #(.DATA_W(8), .NUM_CH(3), .CNT_W(2)) dut3b (
        .clk(clk), .rst(rst), .bus(if3b.slave), .drop_cnt(drop3b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ch4(input int k);
        return if4.out_data[k*8 +: 8];
    endfunction

    task automatic drive3(input logic v, input logic [1:0] sel, input logic [7:0] d);
        if3a.in_valid = v; if3a.in_sel = sel; if3a.in_data = d;
        if3b.in_valid = v; if3b.in_sel = sel; if3b.in_data = d;
    endtask

    // ------------------------------------------------------------------
    // Reference model of the 4-channel instance: one held word per channel,
    // plus per-channel FIFOs of accepted words checked at each consumer
    // handshake (loss / duplication / reordering) and a stall-stability check.
    // ------------------------------------------------------------------
    logic [3:0] m_valid;
    logic [7:0] m_data [4];
    logic [7:0] sb     [4][$];
    logic [3:0] p_stall = 4'b0;
    logic [7:0] p_data [4];

    always @(negedge clk) begin
        logic [3:0] free;
        logic       exp_rdy;
        logic       acc;
        logic [7:0] w;
        for (int k = 0; k < 4; k++) free[k] = !m_valid[k] || if4.out_ready[k];
        if (rst)               exp_rdy = 1'b0;
        else if (if4.in_bcast) exp_rdy = (free == 4'hF);
        else                   exp_rdy = free[if4.in_sel];

        if (armed) begin
            check("m_in_ready", {63'd0, if4.in_ready}, {63'd0, exp_rdy});
            check("m_out_valid", {60'd0, if4.out_valid}, {60'd0, m_valid});
            check("m_drop_cnt", {48'd0, drop4}, 64'd0);
            for (int k = 0; k < 4; k++) begin
                check($sformatf("m_out_data%0d", k), {56'd0, ch4(k)}, {56'd0, m_data[k]});
                if (p_stall[k]) begin
                    check($sformatf("stall_valid%0d", k), {63'd0, if4.out_valid[k]}, 64'd1);
                    check($sformatf("stall_data%0d", k), {56'd0, ch4(k)}, {56'd0, p_data[k]});
                end
                if (!rst && if4.out_valid[k] && if4.out_ready[k]) begin
                    if (sb[k].size() == 0) begin
                        check($sformatf("sb_unexpected%0d", k), 64'd1, 64'd0);
                    end else begin
                        w = sb[k].pop_front();
                        check($sformatf("sb_word%0d", k), {56'd0, ch4(k)}, {56'd0, w});
                    end
                end
            end
        end

        for (int k = 0; k < 4; k++) begin
            p_stall[k] = !rst && if4.out_valid[k] && !if4.out_ready[k];
            p_data[k]  = ch4(k);
        end

        if (rst) begin
            m_valid = 4'b0;
            for (int k = 0; k < 4; k++) begin
                m_data[k] = 8'h00;
                sb[k].delete();
            end
        end else begin
            acc = if4.in_valid && exp_rdy;
            for (int k = 0; k < 4; k++) begin
                if (acc && (if4.in_bcast || (if4.in_sel == 2'(k)))) begin
                    m_valid[k] = 1'b1;
                    m_data[k]  = if4.in_data;
                    sb[k].push_back(if4.in_data);
                end else if (m_valid[k] && if4.out_ready[k]) begin
                    m_valid[k] = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations, then a random soak
    // ------------------------------------------------------------------
    initial begin
        logic [3:0] ev;
        int total;
        rst = 1'b1;
        if4.in_valid = 0; if4.in_data = 0; if4.in_sel = 0; if4.in_bcast = 0; if4.out_ready = 0;
        if3a.in_bcast = 0; if3a.out_ready = 0;
        if3b.in_bcast = 0; if3b.out_ready = 0;
        drive3(1'b0, 2'd0, 8'h00);
        step();
        armed = 1'b1;
        step();
        rst = 1'b0;

        // Reset mid-stream: ch0 and ch2 stalled
        if4.in_valid = 1; if4.in_sel = 0; if4.in_data = 8'h31;
        step();
        if4.in_sel = 2; if4.in_data = 8'h32;
        step();
        if4.in_valid = 0;
        @(negedge clk);
        check("pre_rst_valid", {60'd0, if4.out_valid}, 64'h5);
        check("pre_rst_ch2", {56'd0, ch4(2)}, 64'h32);
        step();
        rst = 1; if4.in_valid = 1; if4.in_sel = 1; if4.in_data = 8'h77;
        @(negedge clk);
        check("rst_in_ready", {63'd0, if4.in_ready}, 64'd0);
        step();
        rst = 0; if4.in_valid = 0;
        @(negedge clk);
        check("rst_out_valid", {60'd0, if4.out_valid}, 64'd0);
        check("rst_out_data", {32'd0, if4.out_data}, 64'd0);
        check("rst_drop_cnt", {48'd0, drop4}, 64'd0);
        step();

        // Unicast sweep, back to back
        if4.out_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            if4.in_valid = 1; if4.in_sel = 2'(i); if4.in_data = 8'(8'hA0 + i);
            @(negedge clk);
            check("sweep_ready", {63'd0, if4.in_ready}, 64'd1);
            if (i > 0) begin
                ev = 4'(1 << (i - 1));
                check("sweep_valid", {60'd0, if4.out_valid}, {60'd0, ev});
                check("sweep_data", {56'd0, ch4(i - 1)}, 64'(8'hA0 + i - 1));
            end
            step();
        end
        if4.in_valid = 0;
        @(negedge clk);
        check("sweep_valid_last", {60'd0, if4.out_valid}, 64'h8);
        check("sweep_data_last", {56'd0, ch4(3)}, 64'hA3);
        step();

        // Backpressure on channel 1
        if4.out_ready = 4'b1101;
        if4.in_valid = 1; if4.in_sel = 1; if4.in_data = 8'h11;
        @(negedge clk);
        check("bp_ready_first", {63'd0, if4.in_ready}, 64'd1);
        step();
        if4.in_data = 8'h22;
        @(negedge clk);
        check("bp_hold_data", {56'd0, ch4(1)}, 64'h11);
        check("bp_ready_blocked", {63'd0, if4.in_ready}, 64'd0);
        step();
        @(negedge clk);
        check("bp_hold_valid", {60'd0, if4.out_valid}, 64'h2);
        check("bp_hold_data2", {56'd0, ch4(1)}, 64'h11);
        step();
        if4.out_ready = 4'hF;
        @(negedge clk);
        check("bp_ready_release", {63'd0, if4.in_ready}, 64'd1);
        step();
        if4.in_valid = 0;
        @(negedge clk);
        check("bp_nobubble_valid", {60'd0, if4.out_valid}, 64'h2);
        check("bp_nobubble_data", {56'd0, ch4(1)}, 64'h22);
        step();
        @(negedge clk);
        check("bp_drained", {60'd0, if4.out_valid}, 64'd0);
        step();

        // Broadcast atomicity behind a stalled channel 3
        if4.out_ready = 4'b0111;
        if4.in_valid = 1; if4.in_sel = 3; if4.in_bcast = 0; if4.in_data = 8'h33;
        step();
        if4.in_bcast = 1; if4.in_data = 8'h5A;
        @(negedge clk);
        check("bc_blocked_ready", {63'd0, if4.in_ready}, 64'd0);
        check("bc_blocked_valid", {60'd0, if4.out_valid}, 64'h8);
        step();
        @(negedge clk);
        check("bc_none_loaded", {60'd0, if4.out_valid}, 64'h8);
        check("bc_ch3_held", {56'd0, ch4(3)}, 64'h33);
        step();
        if4.out_ready = 4'hF;
        @(negedge clk);
        check("bc_ready", {63'd0, if4.in_ready}, 64'd1);
        step();
        if4.in_valid = 0; if4.in_bcast = 0;
        @(negedge clk);
        check("bc_all_valid", {60'd0, if4.out_valid}, 64'hF);
        for (int k = 0; k < 4; k++) check("bc_data", {56'd0, ch4(k)}, 64'h5A);
        step();

        // Out-of-range select on the 3-channel instances
        drive3(1'b1, 2'd0, 8'h44);
        step();
        drive3(1'b1, 2'd3, 8'hEE);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("ill_ready_a", {63'd0, if3a.in_ready}, 64'd1);
            check("ill_ready_b", {63'd0, if3b.in_ready}, 64'd1);
            check("ill_cnt_a", {48'd0, drop3a}, 64'(i));
            check("ill_cnt_b", {62'd0, drop3b}, 64'((i > 3) ? 3 : i));
            step();
        end
        drive3(1'b0, 2'd0, 8'h00);
        @(negedge clk);
        check("ill_valid_a", {61'd0, if3a.out_valid}, 64'h1);
        check("ill_data_a", {56'd0, if3a.out_data[7:0]}, 64'h44);
        check("ill_drop_a", {48'd0, drop3a}, 64'd6);
        check("ill_drop_b_sat", {62'd0, drop3b}, 64'd3);
        step();

        // Random soak on the 4-channel instance
        for (int n = 0; n < 10000; n++) begin
            if4.in_valid  = ($urandom_range(0, 3) != 0);
            if4.in_sel    = 2'($urandom_range(0, 3));
            if4.in_bcast  = ($urandom_range(0, 7) == 0);
            if4.in_data   = 8'($urandom);
            if4.out_ready = 4'($urandom);
            step();
        end
        if4.in_valid = 0; if4.in_bcast = 0; if4.out_ready = 4'hF;
        step();
        step();
        @(negedge clk);
        total = 0;
        for (int k = 0; k < 4; k++) total += sb[k].size();
        check("soak_sb_empty", 64'(total), 64'd0);
        check("soak_idle", {60'd0, if4.out_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
